// File: rtl/fp_int_acc_if.sv
// Product/result bus between fp_int_mul and fp_int_acc.
// The producer drives the strobe side; the accumulator drives the result side.
interface fp_int_acc_if #(
    parameter int ACC_WIDTH = 32
);
    logic                 start_acc;
    logic                 sign_out;
    logic [4:0]           exp_out;
    logic [13:0]          mantissa_out;
    logic                 flush;
    logic [ACC_WIDTH-1:0] acc_out;
    logic                 out_valid;
    logic                 overflow;

    modport master (
        output start_acc, sign_out, exp_out, mantissa_out, flush,
        input  acc_out, out_valid, overflow
    );

    modport slave (
        input  start_acc, sign_out, exp_out, mantissa_out, flush,
        output acc_out, out_valid, overflow
    );
endinterface

// File: rtl/fp_int_acc.sv
// Two-stage product aligner and group accumulator for the FP-INT MAC column.
// Optional build macro FP_INT_ACC_SAT_EN selects saturating results; the default wraps.
module fp_int_acc #(
    parameter int ACC_WIDTH = 32,
    parameter int FRAC_BITS = 16,
    parameter int NUM_ACC   = 4
) (
    input  logic          clk,
    input  logic          rst,
    fp_int_acc_if.slave   bus
);
    localparam int EXT_W = ACC_WIDTH + 8;
    localparam int SUM_W = ACC_WIDTH + 9;
    localparam int CNT_W = $clog2(NUM_ACC + 1);
    localparam int HI_W  = SUM_W - ACC_WIDTH + 1;

    logic signed [31:0]      sh_s;
    logic [EXT_W-1:0]        mant_ext_s;
    logic [EXT_W-1:0]        mag_s;
    logic [EXT_W-1:0]        aligned_s;

    logic                    s1_valid_r;
    logic [EXT_W-1:0]        s1_aligned_r;
    logic                    flush_pend_r;

    logic [ACC_WIDTH-1:0]    acc_r;
    logic [CNT_W-1:0]        cnt_r;
    logic                    sticky_r;
    logic [ACC_WIDTH-1:0]    acc_out_r;
    logic                    out_valid_r;
    logic                    overflow_r;

    logic [SUM_W-1:0]        addend_s;
    logic [SUM_W-1:0]        sum_s;
    logic [HI_W-1:0]         hi_s;
    logic                    ovf_s;
    logic [ACC_WIDTH-1:0]    result_s;
    logic [CNT_W-1:0]        cnt_inc_s;
    logic                    close_s;

`ifdef FP_INT_ACC_SAT_EN
    localparam logic [ACC_WIDTH-1:0] SAT_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] SAT_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    logic                    sat_lock_r;
`endif

    assign bus.acc_out   = acc_out_r;
    assign bus.out_valid = out_valid_r;
    assign bus.overflow  = overflow_r;

    // Stage-1 alignment: scale the magnitude to FRAC_BITS fractional bits, then apply sign.
    always_comb begin
        sh_s       = $signed({27'd0, bus.exp_out}) + $signed(32'(FRAC_BITS)) - 32'sd25;
        mant_ext_s = {{(EXT_W-14){1'b0}}, bus.mantissa_out};
        if (sh_s >= 32'sd0) begin
            mag_s = mant_ext_s << sh_s;
        end else begin
            mag_s = mant_ext_s >> (-sh_s);
        end
        if (bus.sign_out) begin
            aligned_s = -mag_s;
        end else begin
            aligned_s = mag_s;
        end
    end

    // Stage-1 registers: captured product and flush request travel together.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r   <= 1'b0;
            s1_aligned_r <= {EXT_W{1'b0}};
            flush_pend_r <= 1'b0;
        end else begin
            s1_valid_r   <= bus.start_acc;
            flush_pend_r <= bus.flush;
            if (bus.start_acc) begin
                s1_aligned_r <= aligned_s;
            end else begin
                s1_aligned_r <= s1_aligned_r;
            end
        end
    end

    // Stage-2 add, range check and group-close decision.
    always_comb begin
        if (s1_valid_r) begin
            addend_s  = {{(SUM_W-EXT_W){s1_aligned_r[EXT_W-1]}}, s1_aligned_r};
            cnt_inc_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            addend_s  = {SUM_W{1'b0}};
            cnt_inc_s = cnt_r;
        end
        sum_s = {{(SUM_W-ACC_WIDTH){acc_r[ACC_WIDTH-1]}}, acc_r} + addend_s;
        hi_s  = sum_s[SUM_W-1:ACC_WIDTH-1];
        ovf_s = !((&hi_s) || (~|hi_s));
`ifdef FP_INT_ACC_SAT_EN
        // Once clamped the accumulator holds the rail until the group closes.
        if (sat_lock_r) begin
            result_s = acc_r;
        end else if (ovf_s) begin
            result_s = sum_s[SUM_W-1] ? SAT_MIN : SAT_MAX;
        end else begin
            result_s = sum_s[ACC_WIDTH-1:0];
        end
`else
        result_s = sum_s[ACC_WIDTH-1:0];
`endif
        close_s = (s1_valid_r && (cnt_inc_s == CNT_W'(NUM_ACC))) || flush_pend_r;
    end

    // Accumulator, group counter and registered result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r       <= {ACC_WIDTH{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            sticky_r    <= 1'b0;
            acc_out_r   <= {ACC_WIDTH{1'b0}};
            out_valid_r <= 1'b0;
            overflow_r  <= 1'b0;
`ifdef FP_INT_ACC_SAT_EN
            sat_lock_r  <= 1'b0;
`endif
        end else if (close_s) begin
            acc_out_r   <= result_s;
            out_valid_r <= 1'b1;
            overflow_r  <= sticky_r | ovf_s;
            acc_r       <= {ACC_WIDTH{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            sticky_r    <= 1'b0;
`ifdef FP_INT_ACC_SAT_EN
            sat_lock_r  <= 1'b0;
`endif
        end else begin
            out_valid_r <= 1'b0;
            acc_r       <= result_s;
            cnt_r       <= cnt_inc_s;
            sticky_r    <= sticky_r | ovf_s;
`ifdef FP_INT_ACC_SAT_EN
            sat_lock_r  <= sat_lock_r | ovf_s;
`endif
        end
    end
endmodule

// File: tb/tb_fp_int_acc.sv
// Scoreboard bench for fp_int_acc: expected group results are queued as stimulus
// is driven and compared against each out_valid pulse.
module tb_fp_int_acc;
    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   cyc;
    int   n_valid;
    int   last_valid_cyc;
    int   last_strobe_cyc;
    bit   use_model;

    typedef struct {
        logic [31:0] acc;
        logic        ovf;
    } exp_t;
    exp_t exp_q[$];

    longint macc;
    int     mcnt;
    bit     msticky;
    bit     mlock;

    fp_int_acc_if #(.ACC_WIDTH(32)) bus_if ();

    fp_int_acc #(.ACC_WIDTH(32), .FRAC_BITS(16), .NUM_ACC(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic push_exp(input logic [31:0] a, input logic o);
        exp_t e;
        e.acc = a;
        e.ovf = o;
        exp_q.push_back(e);
    endtask

    function automatic longint align_f(input bit s, input bit [4:0] e, input bit [13:0] m);
        int     sh;
        longint mag;
        sh = int'(e) + 16 - 25;
        if (sh >= 0) mag = longint'(m) << sh;
        else         mag = longint'(m) >> (-sh);
        return s ? -mag : mag;
    endfunction

    task automatic model_clear();
        macc = 0; mcnt = 0; msticky = 0; mlock = 0;
    endtask

    task automatic model_close();
        push_exp(macc[31:0], msticky);
        model_clear();
    endtask

    // Reference accumulator over exact 64-bit arithmetic.
    task automatic model_step(input bit st, input bit s, input bit [4:0] e, input bit [13:0] m, input bit fl);
        longint sum;
        bit     ovf;
        bit     closed;
        closed = 0;
        if (st) begin
            sum = macc + align_f(s, e, m);
            ovf = (sum > 64'sd2147483647) || (sum < -64'sd2147483648);
            msticky |= ovf;
`ifdef FP_INT_ACC_SAT_EN
            if (!mlock) begin
                if (ovf) begin
                    macc  = (sum > 0) ? 64'sd2147483647 : -64'sd2147483648;
                    mlock = 1;
                end else begin
                    macc = sum;
                end
            end
`else
            macc = longint'(int'(sum));
`endif
            mcnt++;
            if (mcnt == 4) begin
                model_close();
                closed = 1;
            end
        end
        if (fl && !closed) model_close();
    endtask

    task automatic step(input bit st, input bit s, input bit [4:0] e, input bit [13:0] m, input bit fl);
        @(negedge clk);
        bus_if.start_acc    = st;
        bus_if.sign_out     = s;
        bus_if.exp_out      = e;
        bus_if.mantissa_out = m;
        bus_if.flush        = fl;
        if (st) last_strobe_cyc = cyc + 1;
        if (use_model) model_step(st, s, e, m, fl);
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 5'd0, 14'd0, 1'b0);
    endtask

    // Output monitor: every pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus_if.out_valid) begin
            n_valid++;
            last_valid_cyc = cyc;
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("acc_out", {32'd0, bus_if.acc_out}, {32'd0, e.acc});
                chk("overflow", {63'd0, bus_if.overflow}, {63'd0, e.ovf});
            end
        end
    end

    initial begin
        int n_before;
        int waited;
        total = 0; bad = 0; cyc = 0; n_valid = 0;
        last_valid_cyc = 0; last_strobe_cyc = 0; use_model = 0;
        model_clear();
        rst = 1'b1;
        bus_if.start_acc = 1'b0; bus_if.sign_out = 1'b0; bus_if.exp_out = 5'd0;
        bus_if.mantissa_out = 14'd0; bus_if.flush = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_acc_out", {32'd0, bus_if.acc_out}, 64'd0);
        chk("rst_out_valid", {63'd0, bus_if.out_valid}, 64'd0);
        chk("rst_overflow", {63'd0, bus_if.overflow}, 64'd0);

        // Four 1.0 products -> 4.0, single pulse two cycles after the last strobe.
        push_exp(32'h0004_0000, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 5'd15, 14'd1024, 1'b0);
        idle(4);
        chk("n_valid_group1", 64'(n_valid), 64'd1);
        chk("latency", 64'(last_valid_cyc - last_strobe_cyc), 64'd1);

        // 1.0 - 2.0 + 0.5 - 0.5 = -1.0
        push_exp(32'hFFFF_0000, 1'b0);
        step(1'b1, 1'b0, 5'd15, 14'd1024, 1'b0);
        step(1'b1, 1'b1, 5'd16, 14'd1024, 1'b0);
        step(1'b1, 1'b0, 5'd14, 14'd1024, 1'b0);
        step(1'b1, 1'b1, 5'd15, 14'd512, 1'b0);
        idle(3);

        // Large products overflow the 32-bit range.
`ifdef FP_INT_ACC_SAT_EN
        push_exp(32'h7FFF_FFFF, 1'b1);
`else
        push_exp(32'hFF00_0000, 1'b1);
`endif
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 5'd31, 14'd16383, 1'b0);
        idle(3);

        // Early flush on the second strobe, then a fresh full group.
        push_exp(32'h0002_0000, 1'b0);
        push_exp(32'h0004_0000, 1'b0);
        step(1'b1, 1'b0, 5'd15, 14'd1024, 1'b0);
        step(1'b1, 1'b0, 5'd15, 14'd1024, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 5'd15, 14'd1024, 1'b0);
        idle(3);

        // Empty-group flush, then a subnormal product closed by flush.
        push_exp(32'h0000_0000, 1'b0);
        step(1'b0, 1'b0, 5'd0, 14'd0, 1'b1);
        idle(2);
        push_exp(32'h0000_0002, 1'b0);
        step(1'b1, 1'b0, 5'd0, 14'd1024, 1'b1);
        idle(3);

        // Reset mid-group drops everything in flight.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 5'd15, 14'd1024, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        bus_if.start_acc = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_before = n_valid;
        chk("midrst_acc_out", {32'd0, bus_if.acc_out}, 64'd0);
        chk("midrst_overflow", {63'd0, bus_if.overflow}, 64'd0);
        idle(3);
        chk("midrst_no_valid", 64'(n_valid - n_before), 64'd0);
        push_exp(32'h0004_0000, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 5'd15, 14'd1024, 1'b0);
        idle(3);

        // Back-to-back groups with no gap; -0 contributes nothing.
        push_exp(32'h0004_0000, 1'b0);
        push_exp(32'h0001_8000, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 5'd15, 14'd1024, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 5'd14, 14'd1024, 1'b0);
        step(1'b1, 1'b1, 5'd20, 14'd0, 1'b0);
        idle(3);

        // Random traffic checked against the reference model.
        model_clear();
        use_model = 1;
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 23)), 14'($urandom_range(0, 16383)),
                 ($urandom_range(0, 9) == 0));
        end
        step(1'b0, 1'b0, 5'd0, 14'd0, 1'b1);
        use_model = 0;

        waited = 0;
        while (exp_q.size() != 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
